fifo_frame_reader: RTL and testbench
====================================

// Module: fifo_frame_reader
// PURPOSE
//  Read-side sequencer for the async sample FIFO, in the rclk domain. Pops audio samples
//  whenever the FIFO is non-empty and downstream can accept, and slices the stream into
//  fixed FRAME_LEN frames (m_last on the final sample) for the FFT/fingerprint stage.
//  Supports graceful stop at a frame boundary, immediate abort and mid-frame starvation accounting.
// PARAMETERS
//  DSIZE     16    sample width, equal to the FIFO data width
//  FRAME_LEN 1024  samples per frame; power of two, >= 2
//  FCNT_W    16    frame_cnt width
// PORTS
//  rclk        in   1              read-domain clock; the only clock
//  rrst_n      in   1              synchronous active-low reset
//  enable      in   1              level; 1 = run, 0 = stop after the current frame completes
//  abort       in   1              pulse; drop the partial frame immediately, go IDLE
//  rempty      in   1              FIFO empty flag (registered in the FIFO)
//  rdata       in   DSIZE          FIFO read data at current raddr, valid while !rempty
//  rinc        out  1              FIFO pop strobe (combinational)
//  m_data      out  DSIZE          output sample (registered)
//  m_valid     out  1              output valid
//  m_ready     in   1              downstream ready
//  m_last      out  1              m_data is sample FRAME_LEN-1 of its frame
//  frame_cnt   out  FCNT_W         completed frames handed off, wraps
//  stall_cnt   out  16             cycles starved mid-frame, saturates at 16'hFFFF
//  busy        out  1              state != IDLE
// BEHAVIOUR
//  Reset (rrst_n=0 at rclk edge):
//   - state=IDLE, sample_idx=0; m_valid=m_last=0, m_data=0, frame_cnt=0, stall_cnt=0.
//   - rinc=0 while rrst_n=0.
//  States:
//   - IDLE -> RUN on enable=1.
//   - RUN -> DRAIN on enable=0 if sample_idx!=0; RUN -> IDLE on enable=0 if sample_idx==0.
//   - DRAIN -> IDLE when the pop of sample FRAME_LEN-1 occurs. DRAIN ignores enable.
//   - Any state -> IDLE on abort (abort has priority over every other transition).
//  Pop rule:
//   - rinc = (state==RUN || state==DRAIN) && !rempty && !abort && (!m_valid || m_ready).
//   - Gives one pop per cycle sustained; there are no bubbles at full throughput.
//  On pop:
//   - m_data<=rdata, m_valid<=1, m_last<=(sample_idx==FRAME_LEN-1).
//   - sample_idx<=sample_idx+1, wrapping to 0 after FRAME_LEN-1.
//   - Latency is 1 cycle from rinc to m_valid.
//  Output hold:
//   - m_valid && !m_ready: m_data, m_last, m_valid are held stable and rinc=0.
//   - m_valid && m_ready && no pop: m_valid<=0, m_last<=0.
//  frame_cnt:
//   - Increments by 1 on each m_valid && m_ready && m_last handshake; wraps at 2^FCNT_W.
//  stall_cnt:
//   - Increments in any cycle with state in {RUN,DRAIN}, sample_idx!=0, rempty=1 and (!m_valid || m_ready).
//   - Saturating. Cleared only by reset.
//  Abort:
//   - Same cycle: rinc forced to 0.
//   - Next edge: m_valid<=0, m_last<=0, sample_idx<=0, state<=IDLE.
//   - Samples already popped are discarded. frame_cnt and stall_cnt are unchanged.
//  Simultaneous enable=0 and last pop in RUN:
//   - Frame completes, then state goes to IDLE (no DRAIN).
//  enable re-asserted while in DRAIN:
//   - Ignored until IDLE is reached; re-entry to RUN happens no earlier than one cycle after reaching IDLE.
//  rempty rising between pops:
//   - Pop simply pauses; the frame resumes with the same sample_idx.
// TESTING
//  1. FRAME_LEN=4, FIFO preloaded with 0..7, enable=1, m_ready=1 ->
//     8 consecutive beats with data 0..7; m_last on data 3 and 7; frame_cnt=2.
//  2. m_ready=0 for 5 cycles mid-frame -> rinc=0 and m_data held for 5 cycles;
//     no sample lost or duplicated after m_ready rises.
//  3. FIFO empties after 2 of 4 samples for 10 cycles, then refilled ->
//     stall_cnt=10; frame resumes at sample_idx 2; m_last on the 4th sample.
//  4. enable=0 after 1st sample of a frame -> DRAIN; exactly 3 more pops; IDLE; busy=0; frame_cnt+1.
//  5. abort after 2 samples with m_valid=1 ->
//     next cycle m_valid=0, state IDLE, frame_cnt unchanged; re-enable starts a new frame at index 0.
//  6. rrst_n=0 for one cycle mid-frame ->
//     all outputs return to reset values; rinc=0 during reset; operation restarts cleanly after release.

Source files
------------

// File: rtl/fifo_frame_reader.sv
// rtl/fifo_frame_reader.sv - read-side FIFO sequencer slicing samples into fixed-length frames
//
// Pops samples from the async sample FIFO (rclk domain) whenever data is available and the
// output register can take it, tagging the last sample of every FRAME_LEN-sample frame.
//
// Ports:
//   rclk, rrst_n        clock, synchronous active-low reset
//   enable              run level; dropping it finishes the current frame before stopping
//   abort               pulse; discards the partial frame and returns to idle
//   rempty, rdata       FIFO empty flag and head-of-FIFO data
//   rinc                FIFO pop strobe (combinational)
//   m_data, m_valid,
//   m_ready, m_last     registered output stream with end-of-frame marker
//   frame_cnt           completed frames handed downstream (wrapping)
//   stall_cnt           cycles starved mid-frame (saturating)
//   busy                sequencer not idle
module fifo_frame_reader #(
    parameter int DSIZE     = 16,
    parameter int FRAME_LEN = 1024,
    parameter int FCNT_W    = 16
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              enable,
    input  logic              abort,
    input  logic              rempty,
    input  logic [DSIZE-1:0]  rdata,
    output logic              rinc,
    output logic [DSIZE-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [15:0]       stall_cnt,
    output logic              busy
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] sample_idx;
    logic             active;
    logic             out_free;
    logic             pop;
    logic             at_last;
    logic             stall_hit;

    always_comb begin
        active    = (state == ST_RUN) || (state == ST_DRAIN);
        // The output register can be (re)loaded when empty or being consumed this cycle.
        out_free  = !m_valid || m_ready;
        pop       = rrst_n && active && !rempty && !abort && out_free;
        at_last   = (sample_idx == LAST_IDX);
        stall_hit = active && (sample_idx != '0) && rempty && out_free;
    end

    assign rinc = pop;
    assign busy = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) begin
                        // A stop that coincides with the final pop completes the frame directly.
                        if (sample_idx == '0)        state_next = ST_IDLE;
                        else if (pop && at_last)     state_next = ST_IDLE;
                        else                         state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && at_last) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state      <= ST_IDLE;
            sample_idx <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= state_next;

            if (abort) begin
                m_valid    <= 1'b0;
                m_last     <= 1'b0;
                sample_idx <= '0;
            end else if (pop) begin
                m_data     <= rdata;
                m_valid    <= 1'b1;
                m_last     <= at_last;
                // FRAME_LEN is a power of two, so the index wraps naturally.
                sample_idx <= sample_idx + IDX_W'(1);
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            if (m_valid && m_ready && m_last) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end

            if (stall_hit && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb/tb_fifo_frame_reader.sv - self-checking bench for fifo_frame_reader
module tb_fifo_frame_reader;

    localparam int DSIZE     = 16;
    localparam int FRAME_LEN = 4;
    localparam int FCNT_W    = 16;

    logic              rclk;
    logic              rrst_n;
    logic              enable;
    logic              abort;
    logic              rempty;
    logic [DSIZE-1:0]  rdata;
    logic              rinc;
    logic [DSIZE-1:0]  m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [FCNT_W-1:0] frame_cnt;
    logic [15:0]       stall_cnt;
    logic              busy;

    fifo_frame_reader #(
        .DSIZE(DSIZE),
        .FRAME_LEN(FRAME_LEN),
        .FCNT_W(FCNT_W)
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .enable(enable),
        .abort(abort),
        .rempty(rempty),
        .rdata(rdata),
        .rinc(rinc),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .frame_cnt(frame_cnt),
        .stall_cnt(stall_cnt),
        .busy(busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        logic [DSIZE-1:0] d;
        logic             l;
    } beat_t;

    logic [DSIZE-1:0] fq[$];
    beat_t            exp_q[$];
    int               pop_idx;
    logic [FCNT_W-1:0] exp_frames;
    logic             hold_empty;
    int               checks;
    int               failures;
    int               hs_total;
    int               pop_total;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic drive_fifo();
        rempty = hold_empty || (fq.size() == 0);
        rdata  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // One clock: scoreboard the handshake before the edge, update the FIFO model after it.
    task automatic step();
        logic  did_pop;
        logic  did_hs;
        logic  was_abort;
        logic  was_rst;
        beat_t b;
        drive_fifo();
        #1;
        did_pop   = rinc;
        did_hs    = m_valid && m_ready;
        was_abort = abort;
        was_rst   = !rrst_n;
        if (did_pop) begin
            chk("rinc_legal", 32'(!rempty && (!m_valid || m_ready) && !abort && rrst_n), 32'd1);
            pop_total++;
        end
        if (did_hs) begin
            hs_total++;
            chk("hs_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("m_data", 32'(m_data), 32'(b.d));
                chk("m_last", 32'(m_last), 32'(b.l));
                if (b.l) exp_frames = exp_frames + FCNT_W'(1);
            end
        end
        @(posedge rclk);
        #1;
        if (was_rst) begin
            exp_q.delete();
            pop_idx    = 0;
            exp_frames = '0;
        end else if (was_abort) begin
            exp_q.delete();
            pop_idx = 0;
        end else if (did_pop) begin
            b.d = fq.pop_front();
            b.l = (pop_idx == FRAME_LEN - 1);
            exp_q.push_back(b);
            pop_idx = (pop_idx + 1) % FRAME_LEN;
        end
        chk("m_valid_model", 32'(m_valid), 32'(exp_q.size() != 0));
        chk("frame_cnt_model", 32'(frame_cnt), 32'(exp_frames));
        drive_fifo();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(DSIZE'(first + i));
    endtask

    initial begin
        int hs0;
        int pop0;
        int need;
        checks     = 0;
        failures   = 0;
        hs_total   = 0;
        pop_total  = 0;
        pop_idx    = 0;
        exp_frames = '0;
        hold_empty = 1'b0;
        rrst_n     = 1'b0;
        enable     = 1'b1;
        abort      = 1'b0;
        m_ready    = 1'b1;
        fq.push_back(16'hAAAA);
        drive_fifo();

        // Reset with data available and enable high: nothing may pop.
        step();
        #1 chk("rst_rinc", 32'(rinc), 32'd0);
        step();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #1 chk("rst_rinc2", 32'(rinc), 32'd0);
        fq.delete();
        enable = 1'b0;
        rrst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Test 1: two back-to-back frames at full throughput.
        load(0, 8);
        enable = 1'b1;
        hs0 = hs_total;
        steps(2);
        chk("t1_no_early_beat", 32'(hs_total - hs0), 32'd0);
        steps(8);
        chk("t1_beats", 32'(hs_total - hs0), 32'd8);
        chk("t1_frames", 32'(frame_cnt), 32'd2);
        chk("t1_stall", 32'(stall_cnt), 32'd0);
        enable = 1'b0;
        step();
        chk("t1_idle", 32'(busy), 32'd0);

        // Test 2: downstream back-pressure mid-frame.
        load(8, 4);
        enable = 1'b1;
        steps(2);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t2_rinc_held", 32'(rinc), 32'd0);
            step();
            chk("t2_data_held", 32'(m_data), 32'd8);
            chk("t2_valid_held", 32'(m_valid), 32'd1);
        end
        m_ready = 1'b1;
        steps(6);
        chk("t2_frames", 32'(frame_cnt), 32'd3);
        chk("t2_stall", 32'(stall_cnt), 32'd0);

        // Test 3: starvation after two samples of a frame.
        load(12, 2);
        steps(2);
        steps(10);
        chk("t3_stall", 32'(stall_cnt), 32'd10);
        chk("t3_busy", 32'(busy), 32'd1);
        load(14, 2);
        steps(4);
        chk("t3_frames", 32'(frame_cnt), 32'd4);
        chk("t3_stall_after", 32'(stall_cnt), 32'd10);

        // Test 4: graceful stop one sample into a frame.
        load(16, 8);
        step();
        enable = 1'b0;
        pop0 = pop_total;
        steps(8);
        chk("t4_drain_pops", 32'(pop_total - pop0), 32'd3);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_frames", 32'(frame_cnt), 32'd5);
        chk("t4_fifo_left", 32'(fq.size()), 32'd4);

        // Test 5: abort with a pending output sample.
        enable = 1'b1;
        steps(3);
        m_ready = 1'b0;
        abort   = 1'b1;
        #1 chk("t5_rinc_abort", 32'(rinc), 32'd0);
        step();
        abort = 1'b0;
        chk("t5_valid", 32'(m_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_frames", 32'(frame_cnt), 32'd5);
        m_ready = 1'b1;
        load(24, 2);
        steps(8);
        chk("t5_frames_after", 32'(frame_cnt), 32'd6);

        // Test 6: one-cycle reset mid-frame.
        load(30, 8);
        steps(3);
        rrst_n = 1'b0;
        #1 chk("t6_rinc_rst", 32'(rinc), 32'd0);
        step();
        chk("t6_valid", 32'(m_valid), 32'd0);
        chk("t6_data", 32'(m_data), 32'd0);
        chk("t6_frames", 32'(frame_cnt), 32'd0);
        chk("t6_stall", 32'(stall_cnt), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        rrst_n = 1'b1;
        load(38, 3);
        steps(12);
        chk("t6_frames_after", 32'(frame_cnt), 32'd2);

        // Randomised traffic: random back-pressure, FIFO gaps and data.
        for (int i = 0; i < 400; i++) begin
            m_ready    = ($urandom_range(0, 3) != 0);
            hold_empty = ($urandom_range(0, 4) == 0);
            if (fq.size() < 4) fq.push_back(DSIZE'($urandom));
            step();
        end
        m_ready    = 1'b1;
        hold_empty = 1'b0;
        need = (FRAME_LEN - ((pop_idx + fq.size()) % FRAME_LEN)) % FRAME_LEN;
        for (int i = 0; i < need; i++) fq.push_back(DSIZE'($urandom));
        steps(40);
        chk("rnd_fifo_empty", 32'(fq.size()), 32'd0);
        chk("rnd_frame_boundary", 32'(pop_idx), 32'd0);
        chk("rnd_valid", 32'(m_valid), 32'd0);
        enable = 1'b0;
        steps(2);
        chk("rnd_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
